// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential advance, stall hold, and branch redirect with a one-entry pending target.
// A redirect reaches PC one cycle after PcSel when fetch_ready is high; otherwise one cycle after the first ready cycle in WAIT.
module pc_redirect_ctrl #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             fetch_ready,
  output logic [PC_W-1:0]  PC,
  output logic             fetch_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_pending,
  output logic             misalign_err,
  output logic             range_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pend_q, pend_d;
  logic             misalign_q, misalign_d;
  logic             range_q, range_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  tgt;

  assign tgt = {BrPC[PC_W-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    misalign_d = misalign_q;
    range_d    = range_q;
    cnt_d      = cnt_q;

    if (PcSel) begin
      if (BrPC[1:0] != 2'b00)     misalign_d = 1'b1;
      if (BrPC[31:PC_W] != '0)    range_d    = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d      = cnt_q + CNT_W'(1);
    end

    if (state_q == ST_RUN) begin
      if (PcSel) begin
        if (fetch_ready) begin
          pc_d = tgt;
        end else begin
          pend_d  = tgt;
          state_d = ST_WAIT;
        end
      end else if (!stall && fetch_ready) begin
        pc_d = pc_q + PC_W'(4);
      end
    end else begin
      // Newest target wins; a simultaneous ready loads it straight into PC.
      if (PcSel && fetch_ready) begin
        pc_d    = tgt;
        state_d = ST_RUN;
      end else if (PcSel) begin
        pend_d = tgt;
      end else if (fetch_ready) begin
        pc_d    = pend_q;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      misalign_q <= misalign_d;
      range_q    <= range_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PC               = pc_q;
  assign fetch_valid      = !reset && (state_q == ST_RUN);
  assign redirect_pending = !reset && (state_q == ST_WAIT);
  assign flush_if_id      = !reset && (PcSel || (state_q == ST_WAIT));
  assign flush_id_ex      = flush_if_id;
  assign misalign_err     = misalign_q;
  assign range_err        = range_q;
  assign redirect_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_redirect_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = '0;
  logic        fetch_ready = 1'b0;
  logic [8:0]  PC;
  logic        fetch_valid, flush_if_id, flush_id_ex, redirect_pending, misalign_err, range_err;
  logic [3:0]  redirect_cnt;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [8:0] m_pc, m_pend;
  logic       m_wait, m_mis, m_rng;
  int         m_cnt;
  logic       exp_flush, exp_fv, exp_rp;
  logic       obs_flush, obs_flush2, obs_fv, obs_rp;

  pc_redirect_ctrl #(.PC_W(9), .RESET_PC(9'h000), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PcSel(PcSel), .BrPC(BrPC),
    .fetch_ready(fetch_ready), .PC(PC), .fetch_valid(fetch_valid),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_pending(redirect_pending), .misalign_err(misalign_err),
    .range_err(range_err), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 9'h000; m_pend = 9'h000; m_wait = 1'b0; m_mis = 1'b0; m_rng = 1'b0; m_cnt = 0;
  endtask

  // One clock of the architectural rules, applied at the edge.
  task automatic model_update(input logic ps, input logic [31:0] br, input logic st, input logic fr);
    logic [8:0] t;
    t = 9'((br % 512) - (br % 4));
    if (ps) begin
      if (m_cnt < 15) m_cnt = m_cnt + 1;
      if (br % 4 != 0) m_mis = 1'b1;
      if (br >= 512) m_rng = 1'b1;
    end
    if (!m_wait) begin
      if (ps) begin
        if (fr) m_pc = t;
        else begin m_pend = t; m_wait = 1'b1; end
      end else if (!st && fr) begin
        m_pc = 9'((32'(m_pc) + 4) % 512);
      end
    end else begin
      if (ps) begin
        if (fr) begin m_pc = t; m_wait = 1'b0; end
        else m_pend = t;
      end else if (fr) begin
        m_pc = m_pend; m_wait = 1'b0;
      end
    end
  endtask

  // Drive one cycle starting just after a rising edge; captures combinational outputs before the next edge.
  task automatic step(input logic ps, input logic [31:0] br, input logic st, input logic fr);
    PcSel = ps; BrPC = br; stall = st; fetch_ready = fr;
    exp_flush = ps | m_wait; exp_fv = ~m_wait; exp_rp = m_wait;
    #3;
    obs_flush = flush_if_id; obs_flush2 = flush_id_ex; obs_fv = fetch_valid; obs_rp = redirect_pending;
    @(posedge clk); #1;
    model_update(ps, br, st, fr);
  endtask

  task automatic apply_reset();
    PcSel = 1'b0; BrPC = '0; stall = 1'b0; fetch_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; PcSel = 1'b1; fetch_ready = 1'b1;
    #1;
    checks++; if (PC !== 9'h000) $display("FAIL reset_pc got=%h exp=000", PC); else passed++;
    checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_fv got=%b exp=0", fetch_valid); else passed++;
    checks++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) $display("FAIL reset_flush got=%b%b exp=00", flush_if_id, flush_id_ex); else passed++;
    checks++; if (redirect_pending !== 1'b0) $display("FAIL reset_pend got=%b exp=0", redirect_pending); else passed++;
    checks++; if (misalign_err !== 1'b0 || range_err !== 1'b0) $display("FAIL reset_err got=%b%b exp=00", misalign_err, range_err); else passed++;
    checks++; if (redirect_cnt !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", redirect_cnt); else passed++;
    apply_reset();
  endtask

  task automatic test_sequential();
    apply_reset();
    checks++; if (PC !== 9'h000) $display("FAIL seq_start got=%h exp=000", PC); else passed++;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (obs_fv !== 1'b1 || obs_flush !== 1'b0) $display("FAIL seq_ctl%0d fv=%b flush=%b exp fv=1 flush=0", i, obs_fv, obs_flush); else passed++;
      checks++; if (PC !== 9'(4 * i)) $display("FAIL seq_pc%0d got=%h exp=%h", i, PC, 9'(4 * i)); else passed++;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(1'b1, 32'h1FC, 1'b0, 1'b1);
    checks++; if (PC !== 9'h1FC) $display("FAIL wrap_load got=%h exp=1fc", PC); else passed++;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (PC !== 9'h000) $display("FAIL wrap_pc got=%h exp=000", PC); else passed++;
  endtask

  task automatic test_stall_redirect();
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      checks++; if (PC !== 9'h008) $display("FAIL stall_pc%0d got=%h exp=008", i, PC); else passed++;
    end
    step(1'b1, 32'h40, 1'b1, 1'b1);
    checks++; if (obs_flush !== 1'b1 || obs_flush2 !== 1'b1) $display("FAIL stall_br_flush got=%b%b exp=11", obs_flush, obs_flush2); else passed++;
    checks++; if (PC !== 9'h040) $display("FAIL stall_br_pc got=%h exp=040", PC); else passed++;
    checks++; if (redirect_cnt !== 4'd1) $display("FAIL stall_br_cnt got=%0d exp=1", redirect_cnt); else passed++;
  endtask

  task automatic test_wait();
    apply_reset();
    step(1'b1, 32'h80, 1'b0, 1'b0);
    checks++; if (obs_flush !== 1'b1 || obs_fv !== 1'b1) $display("FAIL wait_entry flush=%b fv=%b exp flush=1 fv=1", obs_flush, obs_fv); else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (obs_rp !== 1'b1 || obs_fv !== 1'b0 || obs_flush !== 1'b1 || obs_flush2 !== 1'b1)
        $display("FAIL wait_cyc%0d rp=%b fv=%b fl=%b%b exp rp=1 fv=0 fl=11", i, obs_rp, obs_fv, obs_flush, obs_flush2); else passed++;
      checks++; if (PC !== 9'h000) $display("FAIL wait_hold%0d got=%h exp=000", i, PC); else passed++;
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (PC !== 9'h080) $display("FAIL wait_pc got=%h exp=080", PC); else passed++;
    checks++; if (fetch_valid !== 1'b1 || redirect_pending !== 1'b0) $display("FAIL wait_run fv=%b rp=%b exp fv=1 rp=0", fetch_valid, redirect_pending); else passed++;
    checks++; if (redirect_cnt !== 4'd1) $display("FAIL wait_cnt got=%0d exp=1", redirect_cnt); else passed++;
  endtask

  task automatic test_wait_override();
    apply_reset();
    step(1'b1, 32'h80, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    checks++; if (PC !== 9'h000 || redirect_pending !== 1'b1) $display("FAIL ovr_hold pc=%h rp=%b exp pc=000 rp=1", PC, redirect_pending); else passed++;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (PC !== 9'h020) $display("FAIL ovr_pc got=%h exp=020", PC); else passed++;
    checks++; if (redirect_cnt !== 4'd2) $display("FAIL ovr_cnt got=%0d exp=2", redirect_cnt); else passed++;
  endtask

  task automatic test_errors_reset_mid_wait();
    apply_reset();
    step(1'b1, 32'h0000_0203, 1'b0, 1'b1);
    checks++; if (PC !== 9'h000) $display("FAIL err_pc got=%h exp=000", PC); else passed++;
    checks++; if (misalign_err !== 1'b1 || range_err !== 1'b1) $display("FAIL err_set got=%b%b exp=11", misalign_err, range_err); else passed++;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (misalign_err !== 1'b1 || range_err !== 1'b1 || PC !== 9'h008) $display("FAIL err_sticky got=%b%b pc=%h exp=11 pc=008", misalign_err, range_err, PC); else passed++;
    step(1'b1, 32'h100, 1'b0, 1'b0);
    checks++; if (redirect_pending !== 1'b1) $display("FAIL err_wait rp=%b exp=1", redirect_pending); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (PC !== 9'h000 || redirect_pending !== 1'b0) $display("FAIL rstwait pc=%h rp=%b exp pc=000 rp=0", PC, redirect_pending); else passed++;
    checks++; if (misalign_err !== 1'b0 || range_err !== 1'b0 || redirect_cnt !== 4'd0)
      $display("FAIL rstwait_clr err=%b%b cnt=%0d exp err=00 cnt=0", misalign_err, range_err, redirect_cnt); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (obs_fv !== 1'b1 || PC !== 9'h004) $display("FAIL rstwait_run fv=%b pc=%h exp fv=1 pc=004", obs_fv, PC); else passed++;
  endtask

  task automatic test_random();
    logic        ps, st, fr;
    logic [31:0] br;
    int          errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      ps = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 2) == 0);
      fr = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       br = $urandom;
        1:       br = 32'($urandom_range(0, 511)) & 32'h1FC;
        default: br = 32'($urandom_range(0, 511));
      endcase
      step(ps, br, st, fr);
      checks++;
      if (obs_flush !== exp_flush || obs_flush2 !== exp_flush || obs_fv !== exp_fv || obs_rp !== exp_rp ||
          PC !== m_pc || redirect_cnt !== 4'(m_cnt) || misalign_err !== m_mis || range_err !== m_rng) begin
        errs++;
        if (errs <= 5)
          $display("FAIL rand%0d pc=%h/%h fl=%b%b/%b fv=%b/%b rp=%b/%b cnt=%0d/%0d err=%b%b/%b%b (got/exp)",
                   i, PC, m_pc, obs_flush, obs_flush2, exp_flush, obs_fv, exp_fv, obs_rp, exp_rp,
                   redirect_cnt, m_cnt, misalign_err, range_err, m_mis, m_rng);
      end else passed++;
    end
    checks++; if (redirect_cnt !== 4'd15) $display("FAIL rand_sat got=%0d exp=15", redirect_cnt); else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_wrap();
    test_stall_redirect();
    test_wait();
    test_wait_override();
    test_errors_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
